// File: rtl/axioma_tick_scheduler.sv
// Timer clock-select and prescaler block: two 10-bit prescalers, external pin
// edge detection and GTCCR reset/sync control, producing one-cycle count enables.
module axioma_tick_scheduler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] cs0,
  input  logic [2:0] cs1,
  input  logic [2:0] cs2,
  input  logic       t0_pin,
  input  logic       t1_pin,
  input  logic       gtccr_we,
  input  logic [7:0] gtccr_wdata,
  output logic [7:0] gtccr_rdata,
  output logic       tick0,
  output logic       tick1,
  output logic       tick2
);

  localparam int unsigned PSC_W  = 10;
  localparam int unsigned SYNC_W = 2;

  logic [PSC_W-1:0]  psc_s, psc_a;
  logic [PSC_W-1:0]  psc_s_next, psc_a_next;
  logic              tsm, psrasy, psrsync;
  logic              tsm_next, psrasy_next, psrsync_next;
  logic [SYNC_W-1:0] sync0, sync1;
  logic              hist0, hist1;
  logic              tick0_next, tick1_next, tick2_next;

  // Synchronous-prescaler taps, suppressed while the prescaler is held in reset
  logic s_div8, s_div64, s_div256, s_div1024;
  logic a_div8, a_div32, a_div64, a_div128, a_div256, a_div1024;
  logic ext0_fall, ext0_rise, ext1_fall, ext1_rise;

  logic unused_wdata;
  assign unused_wdata = ^gtccr_wdata[6:2];

  assign gtccr_rdata = {tsm, 5'b0, psrasy, psrsync};

  always_comb begin
    s_div8    = (&psc_s[2:0]) & ~psrsync;
    s_div64   = (&psc_s[5:0]) & ~psrsync;
    s_div256  = (&psc_s[7:0]) & ~psrsync;
    s_div1024 = (&psc_s[9:0]) & ~psrsync;
    a_div8    = (&psc_a[2:0]) & ~psrasy;
    a_div32   = (&psc_a[4:0]) & ~psrasy;
    a_div64   = (&psc_a[5:0]) & ~psrasy;
    a_div128  = (&psc_a[6:0]) & ~psrasy;
    a_div256  = (&psc_a[7:0]) & ~psrasy;
    a_div1024 = (&psc_a[9:0]) & ~psrasy;
    ext0_fall = hist0 & ~sync0[SYNC_W-1];
    ext0_rise = ~hist0 & sync0[SYNC_W-1];
    ext1_fall = hist1 & ~sync1[SYNC_W-1];
    ext1_rise = ~hist1 & sync1[SYNC_W-1];
  end

  // Prescaler and GTCCR next state; a write wins over self-clear
  always_comb begin
    psc_s_next   = psrsync ? '0 : psc_s + PSC_W'(1);
    psc_a_next   = psrasy  ? '0 : psc_a + PSC_W'(1);
    tsm_next     = tsm;
    psrasy_next  = psrasy;
    psrsync_next = psrsync;
    if (gtccr_we) begin
      tsm_next     = gtccr_wdata[7];
      psrasy_next  = gtccr_wdata[1];
      psrsync_next = gtccr_wdata[0];
    end else if (!tsm) begin
      psrasy_next  = 1'b0;
      psrsync_next = 1'b0;
    end
  end

  // Clock-select decode; the registered tick reflects the selection before the edge
  always_comb begin
    tick0_next = 1'b0;
    tick1_next = 1'b0;
    tick2_next = 1'b0;
    case (cs0)
      3'b001:  tick0_next = 1'b1;
      3'b010:  tick0_next = s_div8;
      3'b011:  tick0_next = s_div64;
      3'b100:  tick0_next = s_div256;
      3'b101:  tick0_next = s_div1024;
      3'b110:  tick0_next = ext0_fall;
      3'b111:  tick0_next = ext0_rise;
      default: tick0_next = 1'b0;
    endcase
    case (cs1)
      3'b001:  tick1_next = 1'b1;
      3'b010:  tick1_next = s_div8;
      3'b011:  tick1_next = s_div64;
      3'b100:  tick1_next = s_div256;
      3'b101:  tick1_next = s_div1024;
      3'b110:  tick1_next = ext1_fall;
      3'b111:  tick1_next = ext1_rise;
      default: tick1_next = 1'b0;
    endcase
    case (cs2)
      3'b001:  tick2_next = 1'b1;
      3'b010:  tick2_next = a_div8;
      3'b011:  tick2_next = a_div32;
      3'b100:  tick2_next = a_div64;
      3'b101:  tick2_next = a_div128;
      3'b110:  tick2_next = a_div256;
      3'b111:  tick2_next = a_div1024;
      default: tick2_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_s   <= '0;
      psc_a   <= '0;
      tsm     <= 1'b0;
      psrasy  <= 1'b0;
      psrsync <= 1'b0;
      sync0   <= '0;
      sync1   <= '0;
      hist0   <= 1'b0;
      hist1   <= 1'b0;
      tick0   <= 1'b0;
      tick1   <= 1'b0;
      tick2   <= 1'b0;
    end else begin
      psc_s   <= psc_s_next;
      psc_a   <= psc_a_next;
      tsm     <= tsm_next;
      psrasy  <= psrasy_next;
      psrsync <= psrsync_next;
      sync0   <= {sync0[SYNC_W-2:0], t0_pin};
      sync1   <= {sync1[SYNC_W-2:0], t1_pin};
      hist0   <= sync0[SYNC_W-1];
      hist1   <= sync1[SYNC_W-1];
      tick0   <= tick0_next;
      tick1   <= tick1_next;
      tick2   <= tick2_next;
    end
  end

endmodule

// File: tb/tb_axioma_tick_scheduler.sv
// Scoreboard bench for axioma_tick_scheduler: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_axioma_tick_scheduler;

  logic       clk;
  logic       reset_n;
  logic [2:0] cs0, cs1, cs2;
  logic       t0_pin, t1_pin;
  logic       gtccr_we;
  logic [7:0] gtccr_wdata;
  logic [7:0] gtccr_rdata;
  logic       tick0, tick1, tick2;

  typedef struct packed {
    logic       t0;
    logic       t1;
    logic       t2;
    logic [7:0] rd;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks   = 0;
  int    failures = 0;

  axioma_tick_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cs0         (cs0),
    .cs1         (cs1),
    .cs2         (cs2),
    .t0_pin      (t0_pin),
    .t1_pin      (t1_pin),
    .gtccr_we    (gtccr_we),
    .gtccr_wdata (gtccr_wdata),
    .gtccr_rdata (gtccr_rdata),
    .tick0       (tick0),
    .tick1       (tick1),
    .tick2       (tick2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expectation per clock period, compared mid-period
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (q.size() > 0) begin
      e = q.pop_front();
      n = nq.pop_front();
      checks++;
      if ({tick0, tick1, tick2, gtccr_rdata} !== {e.t0, e.t1, e.t2, e.rd}) begin
        failures++;
        $display("FAIL %s @%0t: got t0=%b t1=%b t2=%b rdata=%h, expected t0=%b t1=%b t2=%b rdata=%h",
                 n, $time, tick0, tick1, tick2, gtccr_rdata, e.t0, e.t1, e.t2, e.rd);
      end
    end
  end

  task automatic push(input logic e0, input logic e1, input logic e2,
                      input logic [7:0] rd, input string n);
    exp_t e;
    e.t0 = e0;
    e.t1 = e1;
    e.t2 = e2;
    e.rd = rd;
    q.push_back(e);
    nq.push_back(n);
  endtask

  task automatic cyc(input logic e0, input logic e1, input logic e2,
                     input logic [7:0] rd, input string n);
    @(posedge clk);
    #1;
    push(e0, e1, e2, rd, n);
  endtask

  task automatic wcyc(input logic [7:0] d, input logic e0, input logic e1,
                      input logic e2, input logic [7:0] rd, input string n);
    gtccr_we    = 1'b1;
    gtccr_wdata = d;
    cyc(e0, e1, e2, rd, n);
    gtccr_we    = 1'b0;
    gtccr_wdata = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    push(1'b0, 1'b0, 1'b0, 8'h00, "reset_assert");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "reset_hold");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "reset_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    cs0         = 3'b010;
    cs1         = 3'b000;
    cs2         = 3'b000;
    t0_pin      = 1'b0;
    t1_pin      = 1'b0;
    gtccr_we    = 1'b0;
    gtccr_wdata = 8'h00;

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00, "reset_state");
    reset_n = 1'b1;

    // /8 on tick0 from reset: edges 8, 16, 24
    for (int k = 1; k <= 30; k++) cyc(k % 8 == 0, 1'b0, 1'b0, 8'h00, "div8_t0");

    // /1024 on tick1 and /64 on tick2 together
    cs0 = 3'b000; cs1 = 3'b101; cs2 = 3'b100;
    do_reset();
    for (int k = 1; k <= 1100; k++)
      cyc(1'b0, k % 1024 == 0, k % 64 == 0, 8'h00, "div1024_div64");

    // /1 ignores GTCCR
    cs0 = 3'b001; cs1 = 3'b000; cs2 = 3'b000;
    do_reset();
    for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b0, 1'b0, 8'h00, "div1");
    wcyc(8'h81, 1'b1, 1'b0, 1'b0, 8'h81, "div1_wr81");
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 8'h81, "div1_held");
    wcyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, "div1_wr00");

    // psrsync pulse at edge 12 restarts the /8 phase
    cs0 = 3'b010;
    do_reset();
    for (int k = 1; k <= 11; k++) cyc(k % 8 == 0, 1'b0, 1'b0, 8'h00, "pre_psrsync");
    wcyc(8'h01, 1'b0, 1'b0, 1'b0, 8'h01, "psrsync_wr");
    for (int k = 13; k <= 40; k++)
      cyc((k >= 14) && ((k - 14) % 8 == 7), 1'b0, 1'b0, 8'h00, "psrsync_restart");

    // tsm hold of both prescalers, then release
    cs0 = 3'b010; cs2 = 3'b010;
    do_reset();
    for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00, "pre_hold");
    wcyc(8'h83, 1'b0, 1'b0, 1'b0, 8'h83, "hold_wr83");
    repeat (20) cyc(1'b0, 1'b0, 1'b0, 8'h83, "hold");
    wcyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "release_wr00");
    for (int j = 1; j <= 20; j++) cyc(j % 8 == 0, 1'b0, j % 8 == 0, 8'h00, "post_release");

    // External pins: tick0 falling / tick1 rising, then mirrored
    cs0 = 3'b110; cs1 = 3'b111; cs2 = 3'b000;
    do_reset();
    t0_pin = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 8'h00, "ext_wrong_dir_a");
    t0_pin = 1'b0; t1_pin = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "ext_edge1");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "ext_edge2");
    cyc(1'b1, 1'b1, 1'b0, 8'h00, "ext_edge3");
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00, "ext_single");
    cs0 = 3'b111; cs1 = 3'b110;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "ext_cs_switch");
    t0_pin = 1'b1; t1_pin = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "ext_m_edge1");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "ext_m_edge2");
    cyc(1'b1, 1'b1, 1'b0, 8'h00, "ext_m_edge3");
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00, "ext_m_single");
    t0_pin = 1'b0; t1_pin = 1'b1;
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 8'h00, "ext_wrong_dir_b");

    // Asynchronous reset mid-operation
    cs0 = 3'b001; cs1 = 3'b000;
    wcyc(8'h82, 1'b1, 1'b0, 1'b0, 8'h82, "pre_midreset");
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h82, "pre_midreset");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    push(1'b0, 1'b0, 1'b0, 8'h00, "midreset_async");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "midreset_hold");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
